// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller for Donkey vs Kong.
// Sequences the intro animation, enables gameplay, schedules barrel spawns
// on frame ticks, tracks lives and selects the menu/game/over/win screen.
//
// Optional feature: define GAME_CTRL_SKIP_INTRO_EN to leave the intro on the
// cycle after entry without waiting for the animation to finish.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   start_btn       start key level (edge-detected here)
//   frame_tick      one-cycle pulse per video frame
//   animation       high while the intro animation runs
//   player_hit      player struck by a barrel (used in PLAY only)
//   player_win      player reached the goal (used in PLAY only)
//   start_game      intro animation enable (INTRO/PLAY/HIT)
//   game_en         player/barrel motion enable (PLAY)
//   player_rst      one-cycle respawn pulse on every PLAY entry
//   spawn           one-cycle barrel spawn pulse
//   screen[1:0]     0 menu, 1 game, 2 game over, 3 win
//   lives[1:0]      remaining lives
module game_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned HIT_FRAMES   = 120,
  parameter int unsigned END_FRAMES   = 300,
  parameter int unsigned SPAWN_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       animation,
  input  logic       player_hit,
  input  logic       player_win,
  output logic       start_game,
  output logic       game_en,
  output logic       player_rst,
  output logic       spawn,
  output logic [1:0] screen,
  output logic [1:0] lives
);

  localparam int unsigned CNT_W = 12;

  localparam logic [2:0] ST_MENU  = 3'd0;
  localparam logic [2:0] ST_INTRO = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_HIT   = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;
  localparam logic [2:0] ST_WIN   = 3'd5;

  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_FRAMES - 1);
  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_FRAMES - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [1:0]       lives_d;
  logic [1:0]       screen_d;
  logic             start_q;
  logic             start_edge;
  logic             play_entry;
  logic             play_tick;
  logic             spawn_due;
  logic             frame_state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] spawn_cnt;

`ifdef GAME_CTRL_SKIP_INTRO_EN
  logic anim_unused;
  assign anim_unused = animation;
`endif

  // Start key edge; register resets high so a key held through reset is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_q <= 1'b1;
    else      start_q <= start_btn;
  end

  assign start_edge  = start_btn & ~start_q;
  assign play_entry  = (state_d == ST_PLAY) && (state_q != ST_PLAY);
  assign play_tick   = (state_q == ST_PLAY) && (state_d == ST_PLAY) && frame_tick;
  assign spawn_due   = play_tick && (spawn_cnt == SPAWN_LAST);
  assign frame_state = (state_q == ST_HIT) || (state_q == ST_OVER) || (state_q == ST_WIN);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_MENU;
    else      state_q <= state_d;
  end

  // Next state, lives update and screen select
  always_comb begin
    state_d  = state_q;
    lives_d  = lives;
    screen_d = 2'd0;
    case (state_q)
      ST_MENU: begin
        if (start_edge) begin
          state_d = ST_INTRO;
          lives_d = 2'(LIVES);
        end
      end
      ST_INTRO: begin
`ifdef GAME_CTRL_SKIP_INTRO_EN
        state_d = ST_PLAY;
`else
        if (!animation) state_d = ST_PLAY;
`endif
      end
      ST_PLAY: begin
        // Win outranks a coincident hit
        if (player_win) begin
          state_d = ST_WIN;
        end else if (player_hit) begin
          if (lives <= 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end else begin
            lives_d = lives - 2'd1;
            state_d = ST_HIT;
          end
        end
      end
      ST_HIT: begin
        if (frame_tick && (frame_cnt == HIT_LAST)) state_d = ST_PLAY;
      end
      ST_OVER, ST_WIN: begin
        if (start_edge || (frame_tick && (frame_cnt == END_LAST))) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase

    case (state_d)
      ST_INTRO, ST_PLAY, ST_HIT: screen_d = 2'd1;
      ST_OVER:                   screen_d = 2'd2;
      ST_WIN:                    screen_d = 2'd3;
      default:                   screen_d = 2'd0;
    endcase
  end

  // Shared freeze/end-screen frame counter, cleared on every state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           frame_cnt <= '0;
    else if (state_d != state_q)        frame_cnt <= '0;
    else if (frame_tick && frame_state) frame_cnt <= frame_cnt + 12'd1;
  end

  // Spawn interval counter, restarted on every PLAY entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           spawn_cnt <= '0;
    else if (play_entry) spawn_cnt <= '0;
    else if (spawn_due)  spawn_cnt <= '0;
    else if (play_tick)  spawn_cnt <= spawn_cnt + 12'd1;
  end

  // Registered outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_game <= 1'b0;
      game_en    <= 1'b0;
      player_rst <= 1'b0;
      spawn      <= 1'b0;
      screen     <= 2'd0;
      lives      <= 2'd0;
    end else begin
      start_game <= (state_d == ST_INTRO) || (state_d == ST_PLAY) || (state_d == ST_HIT);
      game_en    <= (state_d == ST_PLAY);
      player_rst <= play_entry;
      spawn      <= spawn_due;
      screen     <= screen_d;
      lives      <= lives_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl.
// Stimulus is applied on the falling clock edge; each applied cycle pushes the
// outputs expected after the next rising edge onto a scoreboard queue, which
// is drained and compared on the following falling edge.
module tb_game_ctrl;

  localparam int unsigned LIVES        = 3;
  localparam int unsigned HIT_FRAMES   = 3;
  localparam int unsigned END_FRAMES   = 20;
  localparam int unsigned SPAWN_FRAMES = 4;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       frame_tick;
  logic       animation;
  logic       player_hit;
  logic       player_win;
  logic       start_game;
  logic       game_en;
  logic       player_rst;
  logic       spawn;
  logic [1:0] screen;
  logic [1:0] lives;
  logic [7:0] act;

  game_ctrl #(
    .LIVES       (LIVES),
    .HIT_FRAMES  (HIT_FRAMES),
    .END_FRAMES  (END_FRAMES),
    .SPAWN_FRAMES(SPAWN_FRAMES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .frame_tick(frame_tick),
    .animation (animation),
    .player_hit(player_hit),
    .player_win(player_win),
    .start_game(start_game),
    .game_en   (game_en),
    .player_rst(player_rst),
    .spawn     (spawn),
    .screen    (screen),
    .lives     (lives)
  );

  assign act = {start_game, game_en, player_rst, spawn, screen, lives};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       sb;
    logic       ft;
    logic       an;
    logic       ph;
    logic       pw;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      nm;
  } sb_t;

  sb_t  q[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] o(input logic sg, input logic ge, input logic pr,
                                   input logic sp, input logic [1:0] scr, input logic [1:0] lv);
    return {sg, ge, pr, sp, scr, lv};
  endfunction

  function automatic logic [7:0] menu_o(input logic [1:0] lv);  return o(0, 0, 0, 0, 2'd0, lv); endfunction
  function automatic logic [7:0] intro_o(input logic [1:0] lv); return o(1, 0, 0, 0, 2'd1, lv); endfunction
  function automatic logic [7:0] hit_o(input logic [1:0] lv);   return o(1, 0, 0, 0, 2'd1, lv); endfunction
  function automatic logic [7:0] over_o(input logic [1:0] lv);  return o(0, 0, 0, 0, 2'd2, lv); endfunction
  function automatic logic [7:0] win_o(input logic [1:0] lv);   return o(0, 0, 0, 0, 2'd3, lv); endfunction
  function automatic logic [7:0] play_o(input logic pr, input logic sp, input logic [1:0] lv);
    return o(1, 1, pr, sp, 2'd1, lv);
  endfunction

  function automatic vec_t v(input logic sb, input logic ft, input logic an,
                             input logic ph, input logic pw, input logic [7:0] e);
    vec_t r;
    r.sb = sb; r.ft = ft; r.an = an; r.ph = ph; r.pw = pw; r.exp = e;
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] a, input logic [7:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got sg/ge/pr/sp/scr/lv=%b expected %b", nm, $time, a, e);
    end
  endtask

  task automatic drain();
    sb_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check(e.nm, act, e.exp);
    end
  endtask

  task automatic step(input logic sb, input logic ft, input logic an, input logic ph,
                      input logic pw, input logic [7:0] e, input string nm);
    sb_t s;
    @(negedge clk);
    drain();
    start_btn  = sb;
    frame_tick = ft;
    animation  = an;
    player_hit = ph;
    player_win = pw;
    s.due = cyc + 1;
    s.exp = e;
    s.nm  = nm;
    q.push_back(s);
  endtask

  task automatic flush();
    @(negedge clk);
    drain();
  endtask

  initial begin
    // Two hits with freezes, spawn restart after resume, then game over
    tbl[0]  = v(0, 1, 0, 0, 0, play_o(0, 0, 2'd3));
    tbl[1]  = v(0, 1, 0, 0, 0, play_o(0, 0, 2'd3));
    tbl[2]  = v(0, 1, 0, 1, 0, hit_o(2'd2));
    tbl[3]  = v(0, 1, 0, 0, 1, hit_o(2'd2));
    tbl[4]  = v(1, 0, 0, 0, 0, hit_o(2'd2));
    tbl[5]  = v(0, 1, 0, 0, 0, hit_o(2'd2));
    tbl[6]  = v(0, 1, 0, 0, 0, play_o(1, 0, 2'd2));
    tbl[7]  = v(0, 1, 0, 0, 0, play_o(0, 0, 2'd2));
    tbl[8]  = v(0, 1, 0, 0, 0, play_o(0, 0, 2'd2));
    tbl[9]  = v(0, 1, 0, 0, 0, play_o(0, 0, 2'd2));
    tbl[10] = v(0, 1, 0, 0, 0, play_o(0, 1, 2'd2));
    tbl[11] = v(0, 0, 0, 1, 0, hit_o(2'd1));
    tbl[12] = v(0, 1, 0, 0, 0, hit_o(2'd1));
    tbl[13] = v(0, 1, 0, 0, 0, hit_o(2'd1));
    tbl[14] = v(0, 1, 0, 0, 0, play_o(1, 0, 2'd1));
    tbl[15] = v(0, 0, 0, 0, 0, play_o(0, 0, 2'd1));
    tbl[16] = v(0, 0, 0, 1, 0, over_o(2'd0));
    tbl[17] = v(0, 0, 0, 1, 1, over_o(2'd0));

    rst        = 1'b0;
    start_btn  = 1'b0;
    frame_tick = 1'b0;
    animation  = 1'b1;
    player_hit = 1'b0;
    player_win = 1'b0;
    #3 check("reset_value", act, 8'h00);
    #19 rst = 1'b1;

    // Start sequence
    step(0, 0, 1, 0, 0, menu_o(2'd0), "menu_idle");
    step(1, 0, 1, 0, 0, intro_o(2'd3), "start_edge");
`ifdef GAME_CTRL_SKIP_INTRO_EN
    step(0, 0, 1, 0, 0, play_o(1, 0, 2'd3), "skip_intro_play");
    step(0, 0, 1, 0, 0, play_o(0, 0, 2'd3), "skip_intro_hold");
`else
    for (int i = 0; i < 49; i++) step(0, 0, 1, 0, 0, intro_o(2'd3), "intro_wait");
    step(0, 0, 0, 0, 0, play_o(1, 0, 2'd3), "intro_done");
`endif

    // Spawn scheduling: pulses on ticks 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 0, 0, 0, play_o(0, (k % 4 == 0), 2'd3), "spawn_tick");
      step(0, 0, 0, 0, 0, play_o(0, 0, 2'd3), "spawn_gap");
    end

    foreach (tbl[i]) step(tbl[i].sb, tbl[i].ft, tbl[i].an, tbl[i].ph, tbl[i].pw, tbl[i].exp, "table");

    // Game-over screen times out to menu, lives held at 0
    for (int i = 1; i <= 20; i++)
      step(0, 1, 0, 0, 0, (i < 20) ? over_o(2'd0) : menu_o(2'd0), "over_timeout");

    // Win priority, early exit on start edge
    step(1, 0, 1, 0, 0, intro_o(2'd3), "restart_edge");
    step(0, 0, 0, 0, 0, play_o(1, 0, 2'd3), "restart_play");
    step(0, 0, 0, 1, 1, win_o(2'd3), "win_priority");
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, win_o(2'd3), "win_hold");
    step(1, 0, 0, 0, 0, menu_o(2'd3), "win_start_exit");

    // Win screen timeout with key held (no new edge)
    step(0, 0, 0, 0, 0, menu_o(2'd3), "menu_lives_held");
    step(1, 0, 1, 0, 0, intro_o(2'd3), "restart_edge2");
    step(1, 0, 0, 0, 0, play_o(1, 0, 2'd3), "restart_play2");
    step(1, 0, 0, 0, 1, win_o(2'd3), "win_enter");
    for (int i = 1; i <= 20; i++)
      step(1, 1, 0, 0, 0, (i < 20) ? win_o(2'd3) : menu_o(2'd3), "win_timeout");
    step(1, 0, 0, 0, 0, menu_o(2'd3), "held_no_start");

    // Reset mid-PLAY with the key held
    step(0, 0, 0, 0, 0, menu_o(2'd3), "menu_release");
    step(1, 0, 0, 0, 0, intro_o(2'd3), "restart_edge3");
    step(1, 0, 0, 0, 0, play_o(1, 0, 2'd3), "restart_play3");
    step(1, 1, 0, 0, 0, play_o(0, 0, 2'd3), "play_before_reset");
    flush();
    #2 rst = 1'b0;
    #1 check("reset_async", act, 8'h00);
    @(negedge clk);
    check("reset_hold", act, 8'h00);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, menu_o(2'd0), "held_after_reset");
    step(0, 0, 1, 0, 0, menu_o(2'd0), "key_released");
    step(1, 0, 1, 0, 0, intro_o(2'd3), "restart_after_reset");
    step(0, 0, 0, 0, 0, play_o(1, 0, 2'd3), "play_after_reset");
    flush();
    flush();

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
